// File: rtl/mod_shift_reduce.sv
// -----------------------------------------------------------------------------
// mod_shift_reduce
//
// Sequential modular reducer computing (a_in * 2^k_in) mod n_in, or plain
// a_in mod n_in when mode_in is high. One restoring shift-subtract step is
// performed per clock: the operand bits are fed MSB first, followed by k zero
// bits, so that the running remainder ends up as (a * 2^k) mod n. Typical use
// is converting operands into the Montgomery domain (R = 2^k).
//
// Ports
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset (aborts silently, no done pulse)
//   start    request, sampled only while busy is low
//   mode_in  0: (a*2^k) mod n   1: a mod n (k ignored)
//   a_in     operand, any value (a_in >= n_in allowed)
//   k_in     shift amount, legal 0..MAX_SHIFT in mode 0
//   n_in     modulus, must be non-zero
//   busy     high from the edge after acceptance until done
//   done     one-cycle pulse, result/err valid while high
//   err      illegal request flag, held until the next accepted start
//   result   remainder, held until the next accepted start
// -----------------------------------------------------------------------------
module mod_shift_reduce #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHIFT_W   = 8,
    parameter int unsigned MAX_SHIFT = 2 * WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               mode_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [SHIFT_W-1:0] k_in,
    input  logic [WIDTH-1:0]   n_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   result
);

    // Iteration counter must hold WIDTH + MAX_SHIFT.
    localparam int unsigned CNT_W = $clog2(WIDTH + MAX_SHIFT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bad_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]   rem_d;
    logic               req_bad_d;
    logic [CNT_W-1:0]   cnt_load_d;

    // One restoring step: t = 2*rem + b evaluated at WIDTH+2 bits so that a
    // modulus with its MSB set cannot overflow the comparison. Because
    // rem < n, t < 2n and a single conditional subtract suffices; the
    // difference is < n and therefore fits back into WIDTH bits.
    function automatic logic [WIDTH-1:0] reduce_step(
        input logic [WIDTH-1:0] rem,
        input logic             b,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] n_ext;
        logic [WIDTH+1:0] r;
        t     = {1'b0, rem, b};
        n_ext = {2'b00, n};
        if (t >= n_ext) begin
            r = t - n_ext;
        end else begin
            r = t;
        end
        return r[WIDTH-1:0];
    endfunction

    // Next remainder, request legality and initial iteration count.
    always_comb begin
        rem_d      = reduce_step(rem_q, a_q[WIDTH-1], n_q);
        req_bad_d  = (n_in == {WIDTH{1'b0}}) ||
                     (!mode_in && (32'(k_in) > MAX_SHIFT));
        cnt_load_d = CNT_W'(WIDTH) + (mode_in ? {CNT_W{1'b0}} : CNT_W'(k_in));
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            a_q      <= {WIDTH{1'b0}};
            n_q      <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a_in;
                        n_q      <= n_in;
                        rem_q    <= {WIDTH{1'b0}};
                        cnt_q    <= cnt_load_d;
                        bad_q    <= req_bad_d;
                        result_q <= {WIDTH{1'b0}};
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        // Illegal requests skip the iterations entirely.
                        state_q  <= req_bad_d ? ST_FIN : ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Shifting a_q left feeds its bits MSB first and then
                    // zeros for the k extra iterations.
                    a_q   <= {a_q[WIDTH-2:0], 1'b0};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_FIN: begin
                    result_q <= bad_q ? {WIDTH{1'b0}} : rem_q;
                    err_q    <= bad_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mod_shift_reduce.sv
// -----------------------------------------------------------------------------
// tb_mod_shift_reduce
//
// Three instances: WIDTH=8 and WIDTH=32 exercised with directed operations
// whose results and latencies are hand-computed, and WIDTH=16 exercised with
// a randomized sweep compared every cycle against a behavioural model that
// computes (a * 2^k) mod n arithmetically and predicts the done latency.
// -----------------------------------------------------------------------------
module tb_mod_shift_reduce;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        s8_start = 1'b0, s8_mode = 1'b0;
    logic [7:0]  s8_a = 8'd0, s8_k = 8'd0, s8_n = 8'd0;
    logic        d8_busy, d8_done, d8_err;
    logic [7:0]  d8_res;

    // WIDTH=32 instance
    logic        s32_start = 1'b0, s32_mode = 1'b0;
    logic [31:0] s32_a = 32'd0, s32_n = 32'd0;
    logic [7:0]  s32_k = 8'd0;
    logic        d32_busy, d32_done, d32_err;
    logic [31:0] d32_res;

    // WIDTH=16 instance
    logic        s16_start = 1'b0, s16_mode = 1'b0;
    logic [15:0] s16_a = 16'd0, s16_n = 16'd0;
    logic [7:0]  s16_k = 8'd0;
    logic        d16_busy, d16_done, d16_err;
    logic [15:0] d16_res;

    mod_shift_reduce #(.WIDTH(8), .SHIFT_W(8), .MAX_SHIFT(16)) u8 (
        .clk(clk), .rstn(rstn), .start(s8_start), .mode_in(s8_mode),
        .a_in(s8_a), .k_in(s8_k), .n_in(s8_n),
        .busy(d8_busy), .done(d8_done), .err(d8_err), .result(d8_res));

    mod_shift_reduce #(.WIDTH(32), .SHIFT_W(8), .MAX_SHIFT(64)) u32 (
        .clk(clk), .rstn(rstn), .start(s32_start), .mode_in(s32_mode),
        .a_in(s32_a), .k_in(s32_k), .n_in(s32_n),
        .busy(d32_busy), .done(d32_done), .err(d32_err), .result(d32_res));

    mod_shift_reduce #(.WIDTH(16), .SHIFT_W(8), .MAX_SHIFT(32)) u16 (
        .clk(clk), .rstn(rstn), .start(s16_start), .mode_in(s16_mode),
        .a_in(s16_a), .k_in(s16_k), .n_in(s16_n),
        .busy(d16_busy), .done(d16_done), .err(d16_err), .result(d16_res));

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: (a * 2^k) mod n by plain arithmetic.
    function automatic longint unsigned refm(input longint unsigned a,
                                             input int k,
                                             input longint unsigned n);
        longint unsigned r;
        r = a % n;
        for (int i = 0; i < k; i++) r = (r * 2) % n;
        return r;
    endfunction

    // ---------------- WIDTH=16 behavioural model ----------------
    logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_perr = 1'b0;
    logic [15:0] m_res = 16'd0, m_pres = 16'd0;
    int          m_left = 0;

    function automatic bit bad16(input logic mode, input logic [7:0] k,
                                 input logic [15:0] n);
        return (n == 16'd0) || (!mode && (k > 8'd32));
    endfunction

    function automatic int left16(input logic mode, input logic [7:0] k,
                                  input logic [15:0] n);
        if (bad16(mode, k, n)) return 1;
        return 16 + (mode ? 0 : int'(k)) + 1;
    endfunction

    function automatic logic [15:0] res16(input logic mode, input logic [7:0] k,
                                          input logic [15:0] n, input logic [15:0] a);
        longint unsigned r;
        if (bad16(mode, k, n)) return 16'd0;
        r = refm(longint'(a), mode ? 0 : int'(k), longint'(n));
        return r[15:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_res <= 16'd0; m_left <= 0; m_perr <= 1'b0; m_pres <= 16'd0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (s16_start) begin
                m_busy <= 1'b1;
                m_res  <= 16'd0;
                m_err  <= 1'b0;
                m_left <= left16(s16_mode, s16_k, s16_n);
                m_perr <= bad16(s16_mode, s16_k, s16_n);
                m_pres <= res16(s16_mode, s16_k, s16_n, s16_a);
            end
        end else begin
            if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1;
                m_res <= m_pres; m_err <= m_perr;
            end
            m_left <= m_left - 1;
        end
    end

    bit cmp_en = 1'b0;

    // Every-cycle comparison of the WIDTH=16 instance against the model.
    always @(negedge clk) begin
        if (cmp_en && rstn) begin
            chk({d16_busy, d16_done, d16_err, d16_res} == {m_busy, m_done, m_err, m_res},
                "u16 cycle {busy,done,err,result}",
                64'({d16_busy, d16_done, d16_err, d16_res}),
                64'({m_busy, m_done, m_err, m_res}));
        end
    end

    // ---------------- directed helpers (u8 / u32) ----------------
    task automatic drive(input bit w32, input logic st, input logic m,
                         input logic [31:0] a, input logic [7:0] k, input logic [31:0] n);
        if (w32) begin
            s32_start = st; s32_mode = m; s32_a = a; s32_k = k; s32_n = n;
        end else begin
            s8_start = st; s8_mode = m; s8_a = a[7:0]; s8_k = k; s8_n = n[7:0];
        end
    endtask

    function automatic logic o_done(input bit w32);
        return w32 ? d32_done : d8_done;
    endfunction
    function automatic logic o_busy(input bit w32);
        return w32 ? d32_busy : d8_busy;
    endfunction
    function automatic logic o_err(input bit w32);
        return w32 ? d32_err : d8_err;
    endfunction
    function automatic logic [31:0] o_res(input bit w32);
        return w32 ? d32_res : {24'd0, d8_res};
    endfunction

    // Issue one request; lat counts edges after the accepting edge until done.
    task automatic run_op(input bit w32, input logic m, input logic [31:0] a,
                          input logic [7:0] k, input logic [31:0] n,
                          input logic [31:0] er, input logic ee, input int el,
                          input bit intf, input string nm);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        drive(w32, 1'b1, m, a, k, n);
        @(posedge clk); #1;
        drive(w32, 1'b0, m, a, k, n);
        while (!o_done(w32) && lat < 300) begin
            if (!o_busy(w32)) busy_ok = 1'b0;
            if (intf && lat == 3) drive(w32, 1'b1, ~m, ~a, k + 8'd1, n + 32'd3);
            else if (intf && lat == 4) drive(w32, 1'b0, m, a, k, n);
            @(posedge clk); #1;
            lat++;
        end
        chk(lat == el, {nm, " latency"}, 64'(lat), 64'(el));
        chk(busy_ok, {nm, " busy held while running"}, 64'(busy_ok), 64'd1);
        chk(o_busy(w32) == 1'b0, {nm, " busy low with done"}, 64'(o_busy(w32)), 64'd0);
        chk(o_res(w32) == er, {nm, " result"}, 64'(o_res(w32)), 64'(er));
        chk(o_err(w32) == ee, {nm, " err"}, 64'(o_err(w32)), 64'(ee));
        @(posedge clk); #1;
        chk({o_done(w32), o_err(w32), o_res(w32)} == {1'b0, ee, er},
            {nm, " done drops, result/err held"},
            64'({o_done(w32), o_err(w32), o_res(w32)}), 64'({1'b0, ee, er}));
    endtask

    localparam int N_OPS = 1200;

    // Random operands for the WIDTH=16 instance, biased to the corner cases.
    task automatic rand16();
        int sel;
        sel = $urandom_range(15, 0);
        if (sel == 0)      s16_n = 16'd0;
        else if (sel <= 2) s16_n = 16'd1;
        else if (sel <= 7) s16_n = 16'h8000 | 16'($urandom);
        else               s16_n = 16'($urandom);
        sel = $urandom_range(7, 0);
        if (sel <= 1)      s16_a = 16'd0;
        else if (sel <= 3) s16_a = s16_n + 16'($urandom_range(32'hFFFF - 32'(s16_n), 0));
        else               s16_a = 16'($urandom);
        sel = $urandom_range(7, 0);
        if (sel == 0)      s16_k = 8'($urandom_range(40, 33));
        else               s16_k = 8'($urandom_range(32, 0));
        s16_mode = ($urandom_range(3, 0) == 0);
    endtask

    initial begin
        int lat;
        int ops;
        int cyc;
        bit no_done;

        // Pin the reference model with hand-computed values.
        chk(refm(5, 3, 13) == 1, "model 5*2^3 mod 13", refm(5, 3, 13), 64'd1);
        chk(refm(200, 0, 7) == 4, "model 200 mod 7", refm(200, 0, 7), 64'd4);
        chk(refm(64'hFFFFFFFF, 32, 64'hFFFFFFFB) == 20, "model w32 conversion",
            refm(64'hFFFFFFFF, 32, 64'hFFFFFFFB), 64'd20);
        chk(refm(1, 64, 64'hFFFFFFFB) == 25, "model 2^64 mod n",
            refm(1, 64, 64'hFFFFFFFB), 64'd25);

        // Reset state while rstn is low.
        #12;
        chk({d8_busy, d8_done, d8_err, d8_res} == 11'd0, "u8 reset state",
            64'({d8_busy, d8_done, d8_err, d8_res}), 64'd0);
        chk({d32_busy, d32_done, d32_err, d32_res} == 35'd0, "u32 reset state",
            64'({d32_busy, d32_done, d32_err, d32_res}), 64'd0);
        chk({d16_busy, d16_done, d16_err, d16_res} == 19'd0, "u16 reset state",
            64'({d16_busy, d16_done, d16_err, d16_res}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        cmp_en = 1'b1;

        // WIDTH=8 directed operations.
        run_op(1'b0, 1'b0, 32'h05, 8'd3,  32'd13,  32'd1, 1'b0, 12, 1'b0, "u8 5*2^3 mod 13");
        run_op(1'b0, 1'b1, 32'd200, 8'd99, 32'd7,  32'd4, 1'b0, 9,  1'b0, "u8 mode1 200 mod 7");
        run_op(1'b0, 1'b1, 32'd200, 8'd99, 32'd0,  32'd0, 1'b1, 1,  1'b0, "u8 n=0 error");
        run_op(1'b0, 1'b0, 32'h05, 8'd17, 32'd13,  32'd0, 1'b1, 1,  1'b0, "u8 k>max error");
        run_op(1'b0, 1'b0, 32'h05, 8'd16, 32'd13,  32'd2, 1'b0, 25, 1'b0, "u8 k=max");
        run_op(1'b0, 1'b0, 32'hAB, 8'd5,  32'd1,   32'd0, 1'b0, 14, 1'b0, "u8 n=1");
        run_op(1'b0, 1'b0, 32'h00, 8'd2,  32'd200, 32'd0, 1'b0, 11, 1'b0, "u8 a=0");
        run_op(1'b0, 1'b0, 32'd200, 8'd0, 32'd7,   32'd4, 1'b0, 9,  1'b0, "u8 k=0 mode0");
        run_op(1'b0, 1'b0, 32'hFF, 8'd8,  32'hFB,  32'd20, 1'b0, 17, 1'b0, "u8 n msb set");
        run_op(1'b0, 1'b0, 32'h05, 8'd3,  32'd13,  32'd1, 1'b0, 12, 1'b1, "u8 start mid-run ignored");

        // Start held high through done: back-to-back operation.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h05, 8'd3, 32'd13);
        @(posedge clk); #1;
        lat = 0;
        while (!d8_done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(lat == 12 && d8_res == 8'd1, "u8 b2b first op latency/result",
            64'({lat[15:0], d8_res}), 64'({16'd12, 8'd1}));
        drive(1'b0, 1'b1, 1'b0, 32'h09, 8'd1, 32'd11);
        @(posedge clk); #1;
        chk({d8_busy, d8_done} == 2'b10, "u8 b2b busy re-asserts after done",
            64'({d8_busy, d8_done}), 64'h2);
        drive(1'b0, 1'b0, 1'b0, 32'h09, 8'd1, 32'd11);
        lat = 0;
        while (!d8_done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(lat == 10 && d8_res == 8'd7 && !d8_err, "u8 b2b second op 9*2 mod 11",
            64'({lat[15:0], d8_err, d8_res}), 64'({16'd10, 1'b0, 8'd7}));

        // WIDTH=32 directed operations.
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB, 32'd20, 1'b0, 65, 1'b0, "u32 conversion");
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 8'd65, 32'hFFFFFFFB, 32'd0,  1'b1, 1,  1'b0, "u32 k>max error");
        run_op(1'b1, 1'b0, 32'h1,        8'd64, 32'hFFFFFFFB, 32'd25, 1'b0, 97, 1'b0, "u32 k=max");

        // Reset mid-run aborts with no done pulse.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB);
        repeat (10) @(posedge clk);
        #1;
        chk(d32_busy == 1'b1, "u32 busy before reset", 64'(d32_busy), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk({d32_busy, d32_done, d32_err, d32_res} == 35'd0, "u32 outputs cleared by reset",
            64'({d32_busy, d32_done, d32_err, d32_res}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        no_done = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (d32_done || d32_busy) no_done = 1'b0;
        end
        chk(no_done, "u32 no done/busy after aborted op", 64'(no_done), 64'd1);
        run_op(1'b1, 1'b0, 32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB, 32'd20, 1'b0, 65, 1'b0, "u32 after reset");

        // WIDTH=16 random sweep; the compare process checks every cycle.
        ops = 0;
        cyc = 0;
        while ((ops < N_OPS || m_busy || s16_start) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (!m_busy) begin
                if (ops < N_OPS && $urandom_range(3, 0) != 0) begin
                    rand16();
                    s16_start = 1'b1;
                    ops++;
                end else begin
                    s16_start = 1'b0;
                end
            end else begin
                if ($urandom_range(7, 0) == 0) begin
                    rand16();
                    s16_start = 1'b1;
                end else begin
                    s16_start = 1'b0;
                end
            end
        end
        s16_start = 1'b0;
        repeat (3) @(negedge clk);
        chk(ops == N_OPS && !m_busy && !d16_busy, "u16 sweep completed within budget",
            64'(ops), 64'(N_OPS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
